// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block: FSM state
// encodings, field-select constants and the adjust prescaler width.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_ADJUST = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

  // ADJ_DIV is limited to 1..7, so three bits hold any prescaler count.
  localparam int PRESC_W = 3;

endpackage

// File: rtl/stopwatch_ctrl_edge_detect.sv
// Rising-edge pulse generator. The output pulse is registered, so it
// appears one clock after the input level is first sampled high and is
// exactly one clock wide.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic hist_q;
  logic rise_q;
  logic hist_d;
  logic rise_d;

  // Next-state: remember the current level and flag a 0->1 transition.
  always_comb begin
    hist_d = sig_i;
    rise_d = sig_i & ~hist_q;
  end

  // History and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause/adjust/done sequencing that drives a
// separate MM:SS counter through one-clock command pulses.
// Optional feature: define STOPWATCH_CTRL_BLINK_EN to blink the selected
// field in ADJUST (toggle on each tick_2hz); otherwise blink is held at 1.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int ADJ_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  input  logic       cnt_dn,
  input  logic       at_zero,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       adj_min,
  output logic       adj_sec,
  output logic       blink,
  output logic [2:0] state,
  output logic       done
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(ADJ_DIV - 1);

  logic               pause_edge_s;
  state_e             state_q,   state_d;
  logic [PRESC_W-1:0] presc_q,   presc_d;
  logic               cnt_en_q,  cnt_en_d;
  logic               cnt_dir_q, cnt_dir_d;
  logic               adj_min_q, adj_min_d;
  logic               adj_sec_q, adj_sec_d;
  logic               done_q,    done_d;

  edge_detect u_pause_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (pause_btn),
    .rise_o (pause_edge_s)
  );

  // Next-state and pulse decode. Priority inside a state is
  // adj > pause edge > terminal condition > tick, so a lower-ranked event
  // never produces a pulse on a cycle where a higher-ranked one fires.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_en_d  = 1'b0;
    adj_min_d = 1'b0;
    adj_sec_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pause_edge_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (adj) begin
          state_d = ST_ADJUST;
        end else if (pause_edge_s) begin
          state_d = ST_PAUSE;
        end else if (cnt_dn && at_zero) begin
          state_d = ST_DONE;
        end else if (tick_1hz) begin
          cnt_en_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (adj) begin
          state_d = ST_ADJUST;
        end else if (pause_edge_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_ADJUST: begin
        if (!adj) begin
          state_d = ST_PAUSE;
        end else if (tick_2hz) begin
          // sel is sampled only when the pulse fires, so a field change
          // lands on the next adjust pulse without disturbing the count.
          if (presc_q == PRESC_LAST) begin
            presc_d = {PRESC_W{1'b0}};
            if (sel == SEL_SEC) begin
              adj_sec_d = 1'b1;
            end else begin
              adj_min_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_ADJUST;
        end
      end
      ST_DONE: begin
        if (adj) begin
          state_d = ST_ADJUST;
        end else if (pause_edge_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Every entry into ADJUST starts a fresh ADJ_DIV count.
    if ((state_d == ST_ADJUST) && (state_q != ST_ADJUST)) begin
      presc_d = {PRESC_W{1'b0}};
    end else begin
      presc_d = presc_d;
    end
    cnt_dir_d = cnt_en_d ? cnt_dn : cnt_dir_q;
    done_d    = (state_d == ST_DONE);
  end

  // State, prescaler and registered command outputs; reset drops any pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= {PRESC_W{1'b0}};
      cnt_en_q  <= 1'b0;
      cnt_dir_q <= 1'b0;
      adj_min_q <= 1'b0;
      adj_sec_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_en_q  <= cnt_en_d;
      cnt_dir_q <= cnt_dir_d;
      adj_min_q <= adj_min_d;
      adj_sec_q <= adj_sec_d;
      done_q    <= done_d;
    end
  end

`ifdef STOPWATCH_CTRL_BLINK_EN
  logic blink_q, blink_d;

  // Blink phase: forced on at ADJUST entry/exit and outside ADJUST,
  // toggled on each half-second tick while staying in ADJUST.
  always_comb begin
    if ((state_d != ST_ADJUST) || (state_q != ST_ADJUST)) begin
      blink_d = 1'b1;
    end else if (tick_2hz) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  // Blink register.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b1;
`endif

  assign cnt_en  = cnt_en_q;
  assign cnt_dir = cnt_dir_q;
  assign adj_min = adj_min_q;
  assign adj_sec = adj_sec_q;
  assign state   = state_q;
  assign done    = done_q;

endmodule
